pipe_stage_reg: RTL and testbench

Generic parametrised pipeline-stage register with a valid/ready handshake and a 2-entry skid buffer. It is the successor to the fixed-field, stall-only stage registers between CPU pipeline stages. The payload is split into a data field and a control field. The control field is forced to a bubble value whenever the stage is empty or flushed, so that legacy consumers which ignore valid still see a NOP (for example, regwrite/memwrite = 0). The block also provides a synchronous flush and a saturating bubble counter for performance monitoring.

---
 rtl/pipe_stage_reg.sv | 169 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Purpose: parametrised pipeline-stage register with a valid/ready handshake and a 2-entry skid buffer.
// Latency: 1 cycle from accept to dn_valid_o; sustains 1 entry/cycle while dn_ready_i = 1.
// Backpressure: the skid register absorbs one entry; up_ready_o is registered and drops only when both entries are held.
//
// Ports:
//   clk_i, rst_i          clock; synchronous active-high reset
//   flush_i               discard all held entries (branch taken / exception)
//   up_valid_i/up_ready_o upstream handshake; up_data_i/up_ctrl_i upstream payload
//   dn_valid_o/dn_ready_i downstream handshake; dn_data_o/dn_ctrl_o main-entry payload
//   bubble_cnt_o          saturating count of cycles with dn_valid_o = 0
module pipe_stage_reg #(
  parameter int unsigned           DATA_W   = 96,
  parameter int unsigned           CTRL_W   = 8,
  parameter logic [CTRL_W-1:0]     CTRL_RST = '0,
  parameter int unsigned           CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  input  logic [CTRL_W-1:0] up_ctrl_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [CTRL_W-1:0] dn_ctrl_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [DATA_W-1:0]   r_m_data;
  logic [CTRL_W-1:0]   r_m_ctrl;
  logic [DATA_W-1:0]   r_s_data;
  logic [CTRL_W-1:0]   r_s_ctrl;
  logic                r_dn_valid;
  logic                r_up_ready;
  logic [CNT_W-1:0]    r_bubble_cnt;

  logic                w_accept;
  logic                w_take;
  logic                w_m_load_in;
  logic                w_m_load_s;
  logic                w_m_clear;
  logic                w_s_load;

  assign w_accept = up_valid_i & r_up_ready;
  assign w_take   = r_dn_valid & dn_ready_i;

  // Next-state and register-load decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_m_load_in = 1'b0;
    w_m_load_s  = 1'b0;
    w_m_clear   = 1'b0;
    w_s_load    = 1'b0;

    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_m_load_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_take) begin
          w_m_load_in = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = ST_FULL;
          w_s_load    = 1'b1;
        end else if (w_take) begin
          w_state_nxt = ST_EMPTY;
          w_m_clear   = 1'b1;
        end
      end
      ST_FULL: begin
        // up_ready_o is low here, so only a take can move the state.
        if (w_take) begin
          w_state_nxt = ST_ONE;
          w_m_load_s  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
        w_m_clear   = 1'b1;
      end
    endcase

    // Flush wins over any simultaneous accept; a simultaneous take is
    // simply consumed since the entry is gone either way.
    if (flush_i) begin
      w_state_nxt = ST_EMPTY;
      w_m_load_in = 1'b0;
      w_m_load_s  = 1'b0;
      w_s_load    = 1'b0;
      w_m_clear   = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake flags are registered from the next state so neither output
  // has a combinational path from dn_ready_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_dn_valid <= 1'b0;
      r_up_ready <= 1'b1;
    end else begin
      r_dn_valid <= (w_state_nxt != ST_EMPTY);
      r_up_ready <= (w_state_nxt != ST_FULL);
    end
  end

  // Main register: the bubble control value is loaded whenever the stage
  // empties, so dn_ctrl_o is a plain register output. Data just holds.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_m_data <= '0;
      r_m_ctrl <= CTRL_RST;
    end else if (w_m_load_in) begin
      r_m_data <= up_data_i;
      r_m_ctrl <= up_ctrl_i;
    end else if (w_m_load_s) begin
      r_m_data <= r_s_data;
      r_m_ctrl <= r_s_ctrl;
    end else if (w_m_clear) begin
      r_m_ctrl <= CTRL_RST;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s_data <= '0;
      r_s_ctrl <= CTRL_RST;
    end else if (w_s_load) begin
      r_s_data <= up_data_i;
      r_s_ctrl <= up_ctrl_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bubble_cnt <= '0;
    end else if (!r_dn_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign up_ready_o   = r_up_ready;
  assign dn_valid_o   = r_dn_valid;
  assign dn_data_o    = r_m_data;
  assign dn_ctrl_o    = r_m_ctrl;
  assign bubble_cnt_o = r_bubble_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Purpose: self-checking bench for pipe_stage_reg using a FIFO scoreboard model.
// Latency: checks 1-cycle accept-to-valid and in-order delivery under backpressure.
// Backpressure: drives random and directed dn_ready_i patterns, holding upstream payload while stalled.
module tb_pipe_stage_reg;

  localparam int unsigned          DW    = 96;
  localparam int unsigned          CW    = 8;
  localparam int unsigned          NW    = 4;
  localparam logic [CW-1:0]        CRST  = 8'h00;
  localparam logic [NW-1:0]        BMAX  = 4'hF;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          flush_i;
  logic          up_valid_i;
  logic          up_ready_o;
  logic [DW-1:0] up_data_i;
  logic [CW-1:0] up_ctrl_i;
  logic          dn_valid_o;
  logic          dn_ready_i;
  logic [DW-1:0] dn_data_o;
  logic [CW-1:0] dn_ctrl_o;
  logic [NW-1:0] bubble_cnt_o;

  pipe_stage_reg #(
    .DATA_W   (DW),
    .CTRL_W   (CW),
    .CTRL_RST (CRST),
    .CNT_W    (NW)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (flush_i),
    .up_valid_i   (up_valid_i),
    .up_ready_o   (up_ready_o),
    .up_data_i    (up_data_i),
    .up_ctrl_i    (up_ctrl_i),
    .dn_valid_o   (dn_valid_o),
    .dn_ready_i   (dn_ready_i),
    .dn_data_o    (dn_data_o),
    .dn_ctrl_o    (dn_ctrl_o),
    .bubble_cnt_o (bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int            n_chk  = 0;
  int            n_fail = 0;
  logic [DW+CW-1:0] sb_q[$];
  logic [NW-1:0] m_bcnt = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: called at a negedge, applies inputs, checks outputs
  // against the model, advances the model, and returns at the next negedge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input logic rdy, input logic fl, input logic rs, output logic acc);
    logic            take;
    logic [DW+CW-1:0] e;
    up_valid_i = v;
    up_data_i  = d;
    up_ctrl_i  = c;
    dn_ready_i = rdy;
    flush_i    = fl;
    rst_i      = rs;
    #1;
    chk("dn_valid", dn_valid_o, sb_q.size() > 0);
    chk("up_ready", up_ready_o, sb_q.size() < 2);
    chk("bubble_cnt", bubble_cnt_o, m_bcnt);
    if (!dn_valid_o) chk("bubble_ctrl", dn_ctrl_o, CRST);
    acc  = v & up_ready_o;
    take = dn_valid_o & rdy;
    if (rs) begin
      sb_q.delete();
      m_bcnt = '0;
      acc    = 1'b0;
    end else begin
      if (sb_q.size() == 0 && m_bcnt != BMAX) m_bcnt = m_bcnt + 1'b1;
      if (take && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("dn_data", dn_data_o, e[DW+CW-1:CW]);
        chk("dn_ctrl", dn_ctrl_o, e[CW-1:0]);
      end
      if (fl) begin
        sb_q.delete();
        acc = 1'b0;
      end else if (acc) begin
        sb_q.push_back({d, c});
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle(input logic rdy);
    logic a;
    step(1'b0, '0, '0, rdy, 1'b0, 1'b0, a);
  endtask

  // Offer one entry and hold it until accepted (bounded).
  task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic rdy);
    logic a;
    int   g;
    a = 1'b0;
    g = 0;
    while (!a && g < 20) begin
      step(1'b1, d, c, rdy, 1'b0, 1'b0, a);
      g++;
    end
    chk("send_accepted", a, 1'b1);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb_q.size() > 0 && g < 20) begin
      idle(1'b1);
      g++;
    end
    chk("drain_empty", sb_q.size(), 0);
  endtask

  initial begin
    logic          a;
    logic          pv;
    logic [DW-1:0] pd;
    logic [CW-1:0] pc;

    rst_i      = 1'b1;
    flush_i    = 1'b0;
    up_valid_i = 1'b0;
    up_data_i  = '0;
    up_ctrl_i  = '0;
    dn_ready_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);

    // Random traffic with occasional flush; payload held while stalled.
    pv = 1'b0;
    pd = '0;
    pc = '0;
    for (int i = 0; i < 300; i++) begin
      if (!pv) begin
        pv = ($urandom_range(0, 2) != 0);
        pd = {$urandom, $urandom, $urandom};
        pc = 8'($urandom);
      end
      step(pv, pd, pc, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), 1'b0, a);
      if (a) pv = 1'b0;
    end

    // Reset from whatever state the random traffic left.
    step(1'b1, 96'h5, 8'h55, 1'b1, 1'b0, 1'b1, a);
    chk("rst_dn_valid", dn_valid_o, 1'b0);
    chk("rst_dn_ctrl", dn_ctrl_o, CRST);
    chk("rst_dn_data", dn_data_o, 96'h0);
    chk("rst_up_ready", up_ready_o, 1'b1);
    chk("rst_bubble", bubble_cnt_o, 4'h0);

    // Streaming at full throughput.
    send(96'h1, 8'h11, 1'b1);
    send(96'h2, 8'h22, 1'b1);
    send(96'h3, 8'h33, 1'b1);
    drain();

    // Backpressure: fill both entries, C waits upstream, then release.
    send(96'hA, 8'hA1, 1'b0);
    send(96'hB, 8'hB2, 1'b0);
    chk("full_up_ready", up_ready_o, 1'b0);
    chk("full_dn_data", dn_data_o, 96'hA);
    step(1'b1, 96'hC, 8'hC3, 1'b0, 1'b0, 1'b0, a);
    chk("full_c_held", a, 1'b0);
    send(96'hC, 8'hC3, 1'b1);
    drain();

    // Flush while full with a simultaneous 0xFF-control offer.
    send(96'h10, 8'h01, 1'b0);
    send(96'h20, 8'h02, 1'b0);
    step(1'b1, 96'hFF, 8'hFF, 1'b0, 1'b1, 1'b0, a);
    chk("flush_dn_valid", dn_valid_o, 1'b0);
    chk("flush_dn_ctrl", dn_ctrl_o, CRST);
    chk("flush_up_ready", up_ready_o, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Reset in FULL while dn_ready_i toggles, then a clean stream.
    send(96'h30, 8'h03, 1'b0);
    send(96'h40, 8'h04, 1'b1);
    send(96'h50, 8'h05, 1'b0);
    idle(1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, a);
    chk("rst_full_valid", dn_valid_o, 1'b0);
    chk("rst_full_ready", up_ready_o, 1'b1);
    send(96'hD, 8'hD4, 1'b1);
    send(96'hE, 8'hE5, 1'b1);
    drain();

    // Saturation of the 4-bit bubble counter.
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, a);
    for (int i = 0; i < 20; i++) idle(1'b0);
    chk("sat_bubble", bubble_cnt_o, 4'hF);
    send(96'h77, 8'h07, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("sat_bubble_after", bubble_cnt_o, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
